// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
// Helpers work on a fixed-width vector; callers zero-extend on the way in and truncate on the way out.
package ring_rr_arbiter_pkg;

  localparam int unsigned MAXN = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef logic [MAXN-1:0] vec_t;

  // Rotate the low n bits of v left by one, with bit n-1 wrapping to bit 0.
  function automatic vec_t rotl1(input vec_t v, input int unsigned n);
    vec_t r;
    r = '0;
    for (int unsigned i = 0; i < MAXN; i++) begin
      if (i < n) r[(i + 1) % n] = v[i];
    end
    return r;
  endfunction

  // Binary index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic int unsigned onehot_idx(input vec_t v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAXN; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_ring_ptr.sv
// One-hot priority pointer register for the ring arbiter.
module ring_ptr #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {{(N-1){1'b0}}, 1'b1};
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring pointer and an optional per-tenure hold limit.
// All outputs are registered; a handover re-arbitrates in the same edge with no dead cycle.
module ring_rr_arbiter
  import ring_rr_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned CW       = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   ptr
);

  state_t         state;
  logic [CW-1:0]  hold_cnt;
  logic [N-1:0]   rot_o;
  logic [N-1:0]   pick_base;
  logic [N-1:0]   picked;
  logic           owner_req;
  logic           timeout;
  logic           handover;

  // Double-width scan: the low copy is masked to bits at/above p, the high copy supplies the wrap.
  function automatic logic [N-1:0] pick(input logic [N-1:0] r, input logic [N-1:0] p);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   res;
    logic           found;
    dbl   = {r, r & ~(p - {{(N-1){1'b0}}, 1'b1})};
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 2 * N; i++) begin
      if (!found && dbl[i]) begin
        res[i % N] = 1'b1;
        found      = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    rot_o     = N'(rotl1(vec_t'(gnt), N));
    owner_req = |(req & gnt);
    timeout   = (HOLD_MAX != 0) && (hold_cnt == CW'(HOLD_MAX));
    handover  = (state == ST_GRANT) && (!owner_req || timeout);
    pick_base = (state == ST_IDLE) ? ptr : rot_o;
    picked    = pick(req, pick_base);
  end

  ring_ptr #(
    .N(N)
  ) u_ptr (
    .clk  (clk),
    .rst  (rst),
    .load (handover),
    .d    (rot_o),
    .q    (ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state     <= ST_GRANT;
            gnt       <= picked;
            gnt_valid <= 1'b1;
            gnt_id    <= IDW'(onehot_idx(vec_t'(picked)));
            hold_cnt  <= CW'(1);
          end
        end
        ST_GRANT: begin
          if (handover) begin
            // Owner has lowest priority here, so a sole requester on timeout is simply re-granted.
            gnt       <= picked;
            gnt_valid <= |picked;
            gnt_id    <= IDW'(onehot_idx(vec_t'(picked)));
            if (|picked) begin
              state    <= ST_GRANT;
              hold_cnt <= CW'(1);
            end else begin
              state    <= ST_IDLE;
              hold_cnt <= '0;
            end
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          gnt_id    <= '0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter (N=4, HOLD_MAX=4): directed table plus model-driven random traffic.
module tb_ring_rr_arbiter;

  localparam int HM = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [3:0] ptr;

  ring_rr_arbiter #(
    .N(4),
    .HOLD_MAX(4),
    .IDW(2),
    .CW(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .ptr       (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] ptr;
  } vector_t;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] ptr;
    string      tag;
  } exp_t;

  vector_t tab[$];
  exp_t    sbq[$];

  int checks = 0;
  int errors = 0;

  logic [3:0] m_gnt;
  logic [3:0] m_ptr;
  int         m_hold;
  logic [3:0] prev_gnt = 4'b0000;
  int         run_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] g);
    int idx;
    idx = 0;
    for (int i = 0; i < 4; i++) if (g[i]) idx = i;
    return idx;
  endfunction

  function automatic logic [3:0] m_pick(input logic [3:0] r, input logic [3:0] p);
    int s;
    s = oh_idx(p);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (s + k) % 4;
      if (r[j]) return 4'b0001 << j;
    end
    return 4'b0000;
  endfunction

  task automatic model_update(input logic r, input logic [3:0] rq);
    logic [3:0] nxt;
    if (r) begin
      m_gnt  = 4'b0000;
      m_ptr  = 4'b0001;
      m_hold = 0;
    end else if (m_gnt == 4'b0000) begin
      if (rq != 4'b0000) begin
        m_gnt  = m_pick(rq, m_ptr);
        m_hold = 1;
      end
    end else if ((rq & m_gnt) == 4'b0000 || m_hold == HM) begin
      nxt    = {m_gnt[2:0], m_gnt[3]};
      m_ptr  = nxt;
      m_gnt  = m_pick(rq, nxt);
      m_hold = (m_gnt != 4'b0000) ? 1 : 0;
    end else begin
      m_hold++;
    end
  endtask

  // One cycle: drive at negedge, push expectation, sample 1 time unit after posedge, pop and compare.
  task automatic drive(input logic r, input logic [3:0] rq, input logic use_tab,
                       input logic [3:0] tg, input logic [3:0] tp, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    model_update(r, rq);
    e.tag = tag;
    if (use_tab) begin
      e.gnt = tg;
      e.ptr = tp;
    end else begin
      e.gnt = m_gnt;
      e.ptr = m_ptr;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.tag, ".gnt"},       32'(gnt),       32'(e.gnt));
    chk({e.tag, ".ptr"},       32'(ptr),       32'(e.ptr));
    chk({e.tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e.gnt != 4'b0000));
    chk({e.tag, ".gnt_id"},    32'(gnt_id),    32'(oh_idx(e.gnt)));
    chk("onehot_or_zero", 32'((gnt & (gnt - 4'b0001)) == 4'b0000), 32'(1));
    chk("valid_vs_gnt",   32'(gnt_valid), 32'(|gnt));
    chk("id_vs_gnt",      32'(gnt_id),    32'(oh_idx(gnt)));
    // Count contested edges on which the same owner kept the grant.
    if (!r && gnt == prev_gnt && gnt != 4'b0000 && (rq & gnt) != 4'b0000 && (rq & ~gnt) != 4'b0000)
      run_len++;
    else
      run_len = 0;
    chk("hold_len", 32'(run_len <= HM - 1), 32'(1));
    prev_gnt = gnt;
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g, input logic [3:0] p, input int times);
    vector_t v;
    v.rst = r;
    v.req = rq;
    v.gnt = g;
    v.ptr = p;
    for (int i = 0; i < times; i++) tab.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rq;
    logic       r;
    rst = 1'b1;
    req = 4'b0000;

    // reset held with all requesting, then the rotating sequence
    add(1'b1, 4'b1111, 4'b0000, 4'b0001, 2);
    add(1'b0, 4'b1111, 4'b0001, 4'b0001, 4);
    add(1'b0, 4'b1111, 4'b0010, 4'b0010, 4);
    add(1'b0, 4'b1111, 4'b0100, 4'b0100, 4);
    add(1'b0, 4'b1111, 4'b1000, 4'b1000, 4);
    add(1'b0, 4'b1111, 4'b0001, 4'b0001, 1);
    // run to gnt=0010, then release into 1001
    add(1'b0, 4'b1111, 4'b0001, 4'b0001, 3);
    add(1'b0, 4'b1111, 4'b0010, 4'b0010, 1);
    add(1'b0, 4'b1001, 4'b1000, 4'b0100, 1);
    // sole requester re-granted across timeouts
    add(1'b0, 4'b0100, 4'b0100, 4'b0001, 4);
    add(1'b0, 4'b0100, 4'b0100, 4'b1000, 5);
    // idle with ptr=1000, wrapping pick, release to idle
    add(1'b0, 4'b0000, 4'b0000, 4'b1000, 2);
    add(1'b0, 4'b0010, 4'b0010, 4'b1000, 1);
    add(1'b0, 4'b0000, 4'b0000, 4'b0100, 1);
    // reset mid-tenure at hold_cnt=2
    add(1'b0, 4'b0100, 4'b0100, 4'b0100, 2);
    add(1'b1, 4'b0100, 4'b0000, 4'b0001, 1);
    add(1'b0, 4'b1111, 4'b0001, 4'b0001, 1);

    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i].rst, tab[i].req, 1'b1, tab[i].gnt, tab[i].ptr, $sformatf("vec%0d", i));
    end

    // random traffic against the reference model
    rq = 4'b1111;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) rq = 4'($urandom_range(0, 15));
      drive(r, rq, 1'b0, 4'b0000, 4'b0000, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
